lsu_dmem: RTL

LSU_DMEM -- requirements
Module: lsu_dmem

---
 rtl/lsu_dmem_pkg.sv | 53 +++++
 rtl/lsu_dmem_align.sv | 74 +++++++
 rtl/lsu_dmem.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/lsu_dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dmem_pkg
// Description : Shared types and constants for the LSU data memory: RISC-V
//               load/store access types, FSM states, byte-lane selectors and
//               the access-legality check.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_dmem_pkg;

    // RISC-V funct3 access-type encodings for loads and stores
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    // Single-outstanding request sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Byte-lane selectors taken from addr[1:0]
    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    // Latency down-counter width; covers load values 0..3
    localparam int CNT_W = 2;

    // Alignment/encoding fault check. Range checking depends on the memory
    // depth and is done by the caller.
    function automatic logic access_fault(input logic [2:0] f3,
                                          input logic [1:0] lane,
                                          input logic       we);
        logic f;
        case (f3)
            F3_B, F3_BU: f = 1'b0;
            F3_H, F3_HU: f = lane[0];
            F3_W:        f = (lane != LANE_0);
            default:     f = 1'b1;
        endcase
        // Unsigned variants only exist for loads
        return f | (we & f3[2]);
    endfunction

endpackage : lsu_dmem_pkg
`default_nettype wire

// File: rtl/lsu_dmem_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dmem_align
// Description : Combinational byte-lane logic. Store side produces the byte
//               enables and the lane-replicated write data; load side picks
//               the addressed byte/half from the read word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_dmem_align
    import lsu_dmem_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_lane_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_data_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_lane_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store byte enables; data is replicated so each enabled lane already
    // holds the right bits and the memory write needs no shifter.
    always_comb begin
        be_o      = 4'b0000;
        st_data_o = 32'h0;
        case (st_funct3_i)
            F3_B: begin
                be_o      = 4'b0001 << st_lane_i;
                st_data_o = {4{st_data_i[7:0]}};
            end
            F3_H: begin
                be_o      = st_lane_i[1] ? 4'b1100 : 4'b0011;
                st_data_o = {2{st_data_i[15:0]}};
            end
            F3_W: begin
                be_o      = 4'b1111;
                st_data_o = st_data_i;
            end
            default: begin
                be_o      = 4'b0000;
                st_data_o = 32'h0;
            end
        endcase
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        w_byte    = 8'h0;
        w_half    = ld_lane_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
        ld_data_o = 32'h0;
        case (ld_lane_i)
            LANE_0:  w_byte = ld_word_i[7:0];
            LANE_1:  w_byte = ld_word_i[15:8];
            LANE_2:  w_byte = ld_word_i[23:16];
            LANE_3:  w_byte = ld_word_i[31:24];
            default: w_byte = 8'h0;
        endcase
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{w_byte[7]}}, w_byte};
            F3_BU:   ld_data_o = {24'h0, w_byte};
            F3_H:    ld_data_o = {{16{w_half[15]}}, w_half};
            F3_HU:   ld_data_o = {16'h0, w_half};
            F3_W:    ld_data_o = ld_word_i;
            default: ld_data_o = 32'h0;
        endcase
    end

endmodule : lsu_dmem_align
`default_nettype wire

// File: rtl/lsu_dmem.sv
`default_nettype none
// ============================================================================
// Module      : lsu_dmem
// Description : Load/store data memory with valid/ready request and response
//               channels, one outstanding access, configurable response
//               latency, byte/half/word accesses and access fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_dmem
    import lsu_dmem_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault
);

    localparam int               IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               load_ok_q;
    logic               fault_q;
    logic [2:0]         f3_q;
    logic [1:0]         lane_q;
    logic [31:0]        rd_word_q;

    logic               w_accept;
    logic               w_oob;
    logic               w_fault;
    logic               w_wr_en;
    logic               w_rd_en;
    logic [IDX_W-1:0]   w_idx;
    logic [3:0]         w_be;
    logic [31:0]        w_st_data;
    logic [31:0]        w_ld_data;

    reg [31:0] mem [0:DEPTH_WORDS-1];

    // Ready is held low while reset is asserted, and only IDLE takes requests
    assign req_ready = resetn && (state_q == ST_IDLE);
    assign w_accept  = req_valid && req_ready;

    // Any set address bit above the word index means the access is off the end
    assign w_idx   = req_addr[IDX_W+1:2];
    assign w_oob   = |req_addr[31:IDX_W+2];
    assign w_fault = w_oob || access_fault(req_funct3, req_addr[1:0], req_we);
    assign w_wr_en = w_accept && req_we && !w_fault;
    assign w_rd_en = w_accept && !req_we && !w_fault;

    lsu_dmem_align u_align (
        .st_funct3_i (req_funct3),
        .st_lane_i   (req_addr[1:0]),
        .st_data_i   (req_wdata),
        .be_o        (w_be),
        .st_data_o   (w_st_data),
        .ld_funct3_i (f3_q),
        .ld_lane_i   (lane_q),
        .ld_word_i   (rd_word_q),
        .ld_data_o   (w_ld_data)
    );

    // Storage: byte-lane write and registered read, both at the acceptance
    // edge. No reset so contents survive resetn.
    always_ff @(posedge clk) begin
        if (w_wr_en && w_be[0]) mem[w_idx][7:0]   <= w_st_data[7:0];
        if (w_wr_en && w_be[1]) mem[w_idx][15:8]  <= w_st_data[15:8];
        if (w_wr_en && w_be[2]) mem[w_idx][23:16] <= w_st_data[23:16];
        if (w_wr_en && w_be[3]) mem[w_idx][31:24] <= w_st_data[31:24];
        if (w_rd_en)            rd_word_q         <= mem[w_idx];
    end

    // Response metadata captured at acceptance; reset clears it so a dropped
    // response leaves zero data and no fault on the outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            load_ok_q <= 1'b0;
            fault_q   <= 1'b0;
            f3_q      <= 3'b000;
            lane_q    <= LANE_0;
        end else if (w_accept) begin
            load_ok_q <= !req_we && !w_fault;
            fault_q   <= w_fault;
            f3_q      <= req_funct3;
            lane_q    <= req_addr[1:0];
        end
    end

    // FSM state and latency counter registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the counter reaches zero on the edge that enters RESP, so
    // RESP begins READ_LATENCY-1 edges after acceptance and the response is
    // first sampled READ_LATENCY edges after it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    cnt_d   = LAT_LOAD;
                    state_d = (LAT_LOAD == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_fault = fault_q;
    assign rsp_rdata = load_ok_q ? w_ld_data : 32'h0;

endmodule : lsu_dmem
`default_nettype wire
